// File: rtl/popcount_pipe_acc.sv
// Streaming pipelined popcount (ones or zeros per beat) with a per-frame accumulator.
// Build option: define POPCNT_ACC_SAT_EN to saturate the frame total instead of wrapping.
module popcount_pipe_acc #(
    parameter int DATA_W = 32,
    parameter int LEAF_W = 4,
    parameter int ACC_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    data_val_i,
    input  logic                    data_last_i,
    input  logic                    count_zeros_i,
    output logic [$clog2(DATA_W):0] cnt_o,
    output logic                    cnt_val_o,
    output logic [ACC_W-1:0]        acc_o,
    output logic                    acc_val_o,
    output logic                    acc_ovf_o
);

    localparam int N_LEAF  = DATA_W / LEAF_W;
    localparam int L       = $clog2(N_LEAF);
    localparam int LEAF_CW = $clog2(LEAF_W) + 1;

    function automatic logic [LEAF_CW-1:0] leaf_pop(input logic [LEAF_W-1:0] chunk);
        logic [LEAF_CW-1:0] n;
        n = '0;
        for (int b = 0; b < LEAF_W; b++) n = n + LEAF_CW'(chunk[b]);
        return n;
    endfunction

    // Valid and last travel alongside the partial sums, one flag per level.
    logic [L:0] vld;
    logic [L:0] lst;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            vld <= '0;
            lst <= '0;
        end else begin
            vld[0] <= data_val_i;
            lst[0] <= data_val_i & data_last_i;
            for (int k = 1; k <= L; k++) begin
                vld[k] <= vld[k-1];
                lst[k] <= lst[k-1];
            end
        end
    end

    for (genvar k = 0; k <= L; k++) begin : g_lvl
        localparam int N = N_LEAF >> k;
        localparam int W = LEAF_CW + k;
        logic [W-1:0] sum [N];

        if (k == 0) begin : g_leaf
            logic [DATA_W-1:0] word;
            assign word = count_zeros_i ? ~data_i : data_i;

            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) begin
                    for (int i = 0; i < N; i++) sum[i] <= '0;
                end else if (data_val_i) begin
                    for (int i = 0; i < N; i++) sum[i] <= leaf_pop(word[i*LEAF_W +: LEAF_W]);
                end
            end
        end else begin : g_add
            // Sums only move with a valid beat, so the last level holds cnt_o through bubbles.
            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) begin
                    for (int i = 0; i < N; i++) sum[i] <= '0;
                end else if (vld[k-1]) begin
                    for (int i = 0; i < N; i++)
                        sum[i] <= {1'b0, g_lvl[k-1].sum[2*i]} + {1'b0, g_lvl[k-1].sum[2*i+1]};
                end
            end
        end
    end

    assign cnt_o     = g_lvl[L].sum[0];
    assign cnt_val_o = vld[L];

    logic [ACC_W-1:0] run;
    logic             run_ovf;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] run_nxt;
    logic             ovf_nxt;

    // NOTE: combinational logic uses blocking '=' so later lines see earlier results in the same pass.
    always_comb begin
        sum_ext = {1'b0, run} + (ACC_W+1)'(cnt_o);
        ovf_nxt = run_ovf | sum_ext[ACC_W];
`ifdef POPCNT_ACC_SAT_EN
        run_nxt = ovf_nxt ? '1 : sum_ext[ACC_W-1:0];
`else
        run_nxt = sum_ext[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            run       <= '0;
            run_ovf   <= 1'b0;
            acc_o     <= '0;
            acc_val_o <= 1'b0;
            acc_ovf_o <= 1'b0;
        end else begin
            acc_val_o <= 1'b0;
            if (cnt_val_o) begin
                if (lst[L]) begin
                    acc_o     <= run_nxt;
                    acc_ovf_o <= ovf_nxt;
                    acc_val_o <= 1'b1;
                    run       <= '0;
                    run_ovf   <= 1'b0;
                end else begin
                    run     <= run_nxt;
                    run_ovf <= ovf_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_popcount_pipe_acc.sv
// Randomised self-checking bench for popcount_pipe_acc against a frame-level reference model.
// A second instance with an 8-bit accumulator exercises overflow handling.
module tb_popcount_pipe_acc;

    localparam int     DATA_W  = 32;
    localparam int     LEAF_W  = 4;
    localparam int     ACC_W   = 16;
    localparam int     ACC_W_S = 8;
    localparam int     LAT     = 1 + $clog2(DATA_W / LEAF_W);
    localparam longint T       = 10;
`ifdef POPCNT_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        longint t;
        int     v;
        bit     ovf;
    } ev_t;

    logic              clk_i = 1'b0;
    logic              arst_n_i = 1'b1;
    logic [DATA_W-1:0] data_i = '0;
    logic              data_val_i = 1'b0;
    logic              data_last_i = 1'b0;
    logic              count_zeros_i = 1'b0;

    logic [$clog2(DATA_W):0] cnt, cnt_s;
    logic                    cnt_val, cnt_val_s;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W_S-1:0]      acc_s;
    logic                    acc_val, acc_val_s, acc_ovf, acc_ovf_s;

    ev_t obs_cnt[$], obs_cnt_s[$], obs_acc[$], obs_acc_s[$];
    ev_t exp_cnt[$], exp_frm[$];
    int  errors = 0;
    int  checks = 0;
    int  run_sum = 0;

    popcount_pipe_acc #(.DATA_W(DATA_W), .LEAF_W(LEAF_W), .ACC_W(ACC_W)) dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .data_i(data_i), .data_val_i(data_val_i),
        .data_last_i(data_last_i), .count_zeros_i(count_zeros_i),
        .cnt_o(cnt), .cnt_val_o(cnt_val), .acc_o(acc), .acc_val_o(acc_val), .acc_ovf_o(acc_ovf)
    );

    popcount_pipe_acc #(.DATA_W(DATA_W), .LEAF_W(LEAF_W), .ACC_W(ACC_W_S)) dut_s (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .data_i(data_i), .data_val_i(data_val_i),
        .data_last_i(data_last_i), .count_zeros_i(count_zeros_i),
        .cnt_o(cnt_s), .cnt_val_o(cnt_val_s), .acc_o(acc_s), .acc_val_o(acc_val_s),
        .acc_ovf_o(acc_ovf_s)
    );

    always #5 clk_i = ~clk_i;

    // Outputs are registered, so sampling on the falling edge is race-free.
    always @(negedge clk_i) begin
        if (cnt_val)   obs_cnt.push_back('{longint'($time), int'(cnt), 1'b0});
        if (cnt_val_s) obs_cnt_s.push_back('{longint'($time), int'(cnt_s), 1'b0});
        if (acc_val)   obs_acc.push_back('{longint'($time), int'(acc), acc_ovf});
        if (acc_val_s) obs_acc_s.push_back('{longint'($time), int'(acc_s), acc_ovf_s});
    end

    // Frame total as seen through a w-bit accumulator: wrap or saturate, flag any excess.
    function automatic ev_t acc_model(input ev_t f, input int w);
        ev_t r;
        int  max_v;
        max_v = (1 << w) - 1;
        r.t   = f.t;
        r.ovf = f.v > max_v;
        r.v   = !r.ovf ? f.v : (SAT ? max_v : f.v % (1 << w));
        return r;
    endfunction

    task automatic clear_logs();
        obs_cnt.delete(); obs_cnt_s.delete(); obs_acc.delete(); obs_acc_s.delete();
        exp_cnt.delete(); exp_frm.delete();
    endtask

    task automatic drive(input logic [DATA_W-1:0] d, input bit last, input bit zeros);
        int c;
        @(negedge clk_i);
        data_i = d; data_val_i = 1'b1; data_last_i = last; count_zeros_i = zeros;
        c = zeros ? DATA_W - $countones(d) : $countones(d);
        exp_cnt.push_back('{longint'($time) + LAT * T, c, 1'b0});
        run_sum += c;
        if (last) begin
            exp_frm.push_back('{longint'($time) + (LAT + 1) * T, run_sum, 1'b0});
            run_sum = 0;
        end
    endtask

    // Bubbles carry random last/mode/data, which must all be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            data_val_i = 1'b0; data_last_i = 1'($urandom); count_zeros_i = 1'($urandom);
            data_i = $urandom;
        end
    endtask

    task automatic test_reset();
        #2 arst_n_i = 1'b0;
        #1;
        checks += 5;
        if (cnt !== '0)     begin errors++; $display("FAIL reset cnt: got %0d want 0", cnt); end
        if (cnt_val !== 0)  begin errors++; $display("FAIL reset cnt_val: got %0b want 0", cnt_val); end
        if (acc !== '0)     begin errors++; $display("FAIL reset acc: got %0d want 0", acc); end
        if (acc_val !== 0)  begin errors++; $display("FAIL reset acc_val: got %0b want 0", acc_val); end
        if (acc_ovf !== 0)  begin errors++; $display("FAIL reset acc_ovf: got %0b want 0", acc_ovf); end
        repeat (2) @(negedge clk_i);
        arst_n_i = 1'b1;
    endtask

    task automatic test_single_beat();
        clear_logs();
        drive(32'h0000_0000, 1'b1, 1'b0);
        drive(32'hFFFF_FFFF, 1'b1, 1'b0);
        drive(32'h8000_0001, 1'b1, 1'b0);
        idle(LAT + 3);
        checks++;
        if (obs_cnt.size() != 3) begin errors++; $display("FAIL single cnt_beats: got %0d want 3", obs_cnt.size()); end
        for (int i = 0; i < obs_cnt.size() && i < exp_cnt.size(); i++) begin
            checks++;
            if (obs_cnt[i] !== exp_cnt[i]) begin
                errors++;
                $display("FAIL single cnt[%0d]: got %0d at %0d want %0d at %0d", i, obs_cnt[i].v, obs_cnt[i].t, exp_cnt[i].v, exp_cnt[i].t);
            end
        end
        checks++;
        if (obs_acc.size() != 3) begin errors++; $display("FAIL single acc_frames: got %0d want 3", obs_acc.size()); end
        for (int i = 0; i < obs_acc.size() && i < exp_frm.size(); i++) begin
            checks++;
            if (obs_acc[i] !== acc_model(exp_frm[i], ACC_W)) begin
                errors++;
                $display("FAIL single acc[%0d]: got %0d/%0b at %0d want %0d at %0d", i, obs_acc[i].v, obs_acc[i].ovf, obs_acc[i].t, exp_frm[i].v, exp_frm[i].t);
            end
        end
    endtask

    task automatic test_count_zeros();
        clear_logs();
        drive(32'h0000_000F, 1'b1, 1'b1);
        drive(32'hFFFF_FFFF, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) drive($urandom, i == 7, 1'(i));
        idle(LAT + 3);
        checks++;
        if (obs_cnt.size() != exp_cnt.size()) begin errors++; $display("FAIL zeros cnt_beats: got %0d want %0d", obs_cnt.size(), exp_cnt.size()); end
        for (int i = 0; i < obs_cnt.size() && i < exp_cnt.size(); i++) begin
            checks++;
            if (obs_cnt[i] !== exp_cnt[i]) begin
                errors++;
                $display("FAIL zeros cnt[%0d]: got %0d at %0d want %0d at %0d", i, obs_cnt[i].v, obs_cnt[i].t, exp_cnt[i].v, exp_cnt[i].t);
            end
        end
        checks++;
        if (obs_acc.size() != 3) begin errors++; $display("FAIL zeros acc_frames: got %0d want 3", obs_acc.size()); end
        for (int i = 0; i < obs_acc.size() && i < exp_frm.size(); i++) begin
            checks++;
            if (obs_acc[i] !== acc_model(exp_frm[i], ACC_W)) begin
                errors++;
                $display("FAIL zeros acc[%0d]: got %0d at %0d want %0d at %0d", i, obs_acc[i].v, obs_acc[i].t, exp_frm[i].v, exp_frm[i].t);
            end
        end
    endtask

    task automatic test_bubble_frame();
        clear_logs();
        drive(32'h0000_00FF, 1'b0, 1'b0);
        drive(32'h0000_FFFF, 1'b0, 1'b0);
        idle(2);
        drive(32'h0000_0001, 1'b1, 1'b0);
        idle(LAT + 3);
        checks++;
        if (obs_cnt.size() != 3) begin errors++; $display("FAIL bubble cnt_beats: got %0d want 3", obs_cnt.size()); end
        for (int i = 0; i < obs_cnt.size() && i < exp_cnt.size(); i++) begin
            checks++;
            if (obs_cnt[i] !== exp_cnt[i]) begin
                errors++;
                $display("FAIL bubble cnt[%0d]: got %0d at %0d want %0d at %0d", i, obs_cnt[i].v, obs_cnt[i].t, exp_cnt[i].v, exp_cnt[i].t);
            end
        end
        checks++;
        if (obs_acc.size() != 1) begin
            errors++; $display("FAIL bubble acc_frames: got %0d want 1", obs_acc.size());
        end else if (obs_acc[0] !== '{exp_frm[0].t, 25, 1'b0}) begin
            errors++;
            $display("FAIL bubble acc: got %0d/%0b at %0d want 25/0 at %0d", obs_acc[0].v, obs_acc[0].ovf, obs_acc[0].t, exp_frm[0].t);
        end
    endtask

    task automatic test_overflow();
        clear_logs();
        for (int i = 0; i < 9; i++) drive(32'hFFFF_FFFF, i == 8, 1'b0);
        drive(32'h0000_0001, 1'b1, 1'b0);
        idle(LAT + 3);
        checks++;
        if (obs_acc_s.size() != 2) begin
            errors++; $display("FAIL ovf small_frames: got %0d want 2", obs_acc_s.size());
        end else begin
            checks += 2;
            if (obs_acc_s[0] !== '{exp_frm[0].t, SAT ? 255 : 32, 1'b1}) begin
                errors++;
                $display("FAIL ovf small_acc: got %0d/%0b at %0d want %0d/1 at %0d", obs_acc_s[0].v, obs_acc_s[0].ovf, obs_acc_s[0].t, SAT ? 255 : 32, exp_frm[0].t);
            end
            if (obs_acc_s[1] !== '{exp_frm[1].t, 1, 1'b0}) begin
                errors++;
                $display("FAIL ovf small_next: got %0d/%0b want 1/0", obs_acc_s[1].v, obs_acc_s[1].ovf);
            end
        end
        checks++;
        if (obs_acc.size() != 2 || obs_acc[0] !== '{exp_frm[0].t, 288, 1'b0}) begin
            errors++;
            $display("FAIL ovf wide_acc: got %0d frames first %0d want 2 frames first 288", obs_acc.size(), obs_acc.size() > 0 ? obs_acc[0].v : -1);
        end
    endtask

    task automatic test_random_stream();
        clear_logs();
        for (int i = 0; i < 1000; i++) drive($urandom, i == 999 || $urandom_range(0, 7) == 0, 1'($urandom));
        idle(LAT + 3);
        checks += 2;
        if (obs_cnt.size() != 1000) begin errors++; $display("FAIL random cnt_beats: got %0d want 1000", obs_cnt.size()); end
        if (obs_cnt_s.size() != 1000) begin errors++; $display("FAIL random small_beats: got %0d want 1000", obs_cnt_s.size()); end
        for (int i = 0; i < obs_cnt.size() && i < obs_cnt_s.size() && i < exp_cnt.size(); i++) begin
            checks++;
            if (obs_cnt[i] !== exp_cnt[i] || obs_cnt_s[i] !== exp_cnt[i]) begin
                errors++;
                $display("FAIL random cnt[%0d]: got %0d/%0d at %0d want %0d at %0d", i, obs_cnt[i].v, obs_cnt_s[i].v, obs_cnt[i].t, exp_cnt[i].v, exp_cnt[i].t);
            end
        end
        checks += 2;
        if (obs_acc.size() != exp_frm.size()) begin errors++; $display("FAIL random acc_frames: got %0d want %0d", obs_acc.size(), exp_frm.size()); end
        if (obs_acc_s.size() != exp_frm.size()) begin errors++; $display("FAIL random small_frames: got %0d want %0d", obs_acc_s.size(), exp_frm.size()); end
        for (int i = 0; i < obs_acc.size() && i < obs_acc_s.size() && i < exp_frm.size(); i++) begin
            checks++;
            if (obs_acc[i] !== acc_model(exp_frm[i], ACC_W) || obs_acc_s[i] !== acc_model(exp_frm[i], ACC_W_S)) begin
                errors++;
                $display("FAIL random acc[%0d]: got %0d/%0b small %0d/%0b want total %0d at %0d", i, obs_acc[i].v, obs_acc[i].ovf, obs_acc_s[i].v, obs_acc_s[i].ovf, exp_frm[i].v, exp_frm[i].t);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        for (int i = 0; i < 3; i++) drive($urandom | 32'h1, 1'b0, 1'b0);
        @(negedge clk_i);
        arst_n_i = 1'b0; data_val_i = 1'b0;
        #1;
        checks++;
        if ({cnt, cnt_val, acc, acc_val, acc_ovf, acc_s, acc_val_s, acc_ovf_s} !== '0) begin
            errors++;
            $display("FAIL midreset outputs: got cnt=%0d cv=%0b acc=%0d av=%0b ovf=%0b want all 0", cnt, cnt_val, acc, acc_val, acc_ovf);
        end
        clear_logs();
        run_sum = 0;
        repeat (3) @(negedge clk_i);
        arst_n_i = 1'b1;
        idle(LAT + 3);
        checks++;
        if (obs_cnt.size() != 0 || obs_acc.size() != 0) begin
            errors++; $display("FAIL midreset stale: got %0d beats %0d frames want 0 0", obs_cnt.size(), obs_acc.size());
        end
        drive(32'h0000_000F, 1'b0, 1'b0);
        drive(32'h0000_000F, 1'b1, 1'b0);
        idle(LAT + 3);
        checks++;
        if (obs_acc.size() != 1 || obs_acc[0] !== '{exp_frm[0].t, 8, 1'b0}) begin
            errors++;
            $display("FAIL midreset new_frame: got %0d frames first %0d want 1 frame of 8", obs_acc.size(), obs_acc.size() > 0 ? obs_acc[0].v : -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_count_zeros();
        test_bubble_frame();
        test_overflow();
        test_random_stream();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
